// File: rtl/mgmt_register_bank.sv
// Byte-wide management register bank (idcode, IRQ status/enable, sticky errors, per-channel MDIO regs); define MGMT_IRQ_MASK_EN for a writable IRQ enable.
// Reads complete 1 cycle after rd_en; an idcode read stalls while idcode_valid=0 (up to WAIT_TIMEOUT cycles); rd_en during a pending read is dropped; writes never stall.
module mgmt_register_bank #(
    parameter int NUM_MDIO     = 2,
    parameter int NUM_IRQ      = 8,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic [15:0]            rd_addr,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    input  logic                   wr_en,
    input  logic [15:0]            wr_addr,
    input  logic [7:0]             wr_data,
    input  logic                   idcode_valid,
    input  logic [31:0]            idcode,
    input  logic [NUM_IRQ-1:0]     irq_src,
    output logic                   irq,
    input  logic [NUM_MDIO-1:0]    mdio_busy,
    input  logic [16*NUM_MDIO-1:0] mdio_rd_data,
    output logic [16*NUM_MDIO-1:0] mdio_wr_data,
    output logic [5*NUM_MDIO-1:0]  mdio_reg_addr,
    output logic [5*NUM_MDIO-1:0]  mdio_phy_addr,
    output logic [NUM_MDIO-1:0]    mdio_reg_rd,
    output logic [NUM_MDIO-1:0]    mdio_reg_wr
);
    localparam logic [7:0] TMO_LIMIT = 8'(WAIT_TIMEOUT);

    // Channel n lives at word address 0x12+n (byte address 0x48+4n).
    function automatic logic chan_hit(input logic [15:0] a, input int n);
        return a[15:2] == 14'(18 + n);
    endfunction

    logic                pending;
    logic [15:0]         lat_addr;
    logic [7:0]          stall_cnt;
    logic [NUM_IRQ-1:0]  src_q, status, irq_en, w1c;
    logic                timeout_flag, mdio_err;
    logic [NUM_MDIO-1:0] busy_lat;
    logic [15:0]         stat16, en16, rd_sel;
    logic [7:0]          rd_mux;
    logic                rd_go, rd_stall, rd_tmo, rd_done, ctrl_wr, err_set;

    always_comb begin
        stat16 = '0;
        stat16[NUM_IRQ-1:0] = status;
        en16 = '0;
`ifdef MGMT_IRQ_MASK_EN
        en16[NUM_IRQ-1:0] = irq_en;
`endif
        rd_sel   = pending ? lat_addr : rd_addr;
        rd_go    = pending | rd_en;
        rd_stall = rd_go && (rd_sel[15:2] == 14'h0) && !idcode_valid;
        rd_tmo   = rd_stall && (stall_cnt == TMO_LIMIT);
        rd_done  = rd_go && (!rd_stall || rd_tmo);
        case (rd_sel)
            16'h0000: rd_mux = idcode[31:24];
            16'h0001: rd_mux = idcode[23:16];
            16'h0002: rd_mux = idcode[15:8];
            16'h0003: rd_mux = idcode[7:0];
            16'h0020: rd_mux = stat16[7:0];
            16'h0021: rd_mux = stat16[15:8];
            16'h0022: rd_mux = en16[7:0];
            16'h0023: rd_mux = en16[15:8];
            16'h0024: rd_mux = {6'b0, mdio_err, timeout_flag};
            default:  rd_mux = 8'h00;
        endcase
        for (int n = 0; n < NUM_MDIO; n++) begin
            if (chan_hit(rd_sel, n)) begin
                case (rd_sel[1:0])
                    2'd0:    rd_mux = mdio_rd_data[16*n +: 8];
                    2'd1:    rd_mux = mdio_rd_data[16*n+8 +: 8];
                    2'd2:    rd_mux = 8'h00;
                    default: rd_mux = {busy_lat[n], 7'b0};
                endcase
            end
        end
    end

    always_comb begin
        ctrl_wr = wr_en && (wr_addr == 16'h0024);
        err_set = 1'b0;
        for (int n = 0; n < NUM_MDIO; n++) begin
            if (wr_en && chan_hit(wr_addr, n) && (wr_addr[1:0] == 2'd3) && mdio_busy[n])
                err_set = 1'b1;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            w1c[i] = wr_en && (wr_addr == ((i < 8) ? 16'h0020 : 16'h0021)) && wr_data[i % 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            lat_addr  <= '0;
            stall_cnt <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            busy_lat  <= '0;
        end else begin
            rd_valid <= rd_done;
            if (rd_done) begin
                pending   <= 1'b0;
                stall_cnt <= '0;
                rd_data   <= rd_tmo ? 8'hFF : rd_mux;
            end else if (rd_stall) begin
                pending   <= 1'b1;
                lat_addr  <= rd_sel;
                stall_cnt <= stall_cnt + 8'd1;
            end
            for (int n = 0; n < NUM_MDIO; n++) begin
                if (rd_done && chan_hit(rd_sel, n) && (rd_sel[1:0] == 2'd0))
                    busy_lat[n] <= mdio_busy[n];
            end
        end
    end

    // Set terms are ORed in last so a coincident clear loses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q        <= '0;
            status       <= '0;
            irq          <= 1'b0;
            timeout_flag <= 1'b0;
            mdio_err     <= 1'b0;
        end else begin
            src_q        <= irq_src;
            status       <= (status & ~w1c) | (irq_src & ~src_q);
            irq          <= |(status & irq_en);
            timeout_flag <= rd_tmo | (timeout_flag & ~(ctrl_wr & wr_data[0]));
            mdio_err     <= err_set | (mdio_err & ~(ctrl_wr & wr_data[1]));
        end
    end

`ifdef MGMT_IRQ_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= '0;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (wr_en && (wr_addr == ((i < 8) ? 16'h0022 : 16'h0023)))
                    irq_en[i] <= wr_data[i % 8];
            end
        end
    end
`else
    assign irq_en = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdio_wr_data  <= '0;
            mdio_reg_addr <= '0;
            mdio_phy_addr <= '0;
            mdio_reg_rd   <= '0;
            mdio_reg_wr   <= '0;
        end else begin
            mdio_reg_rd <= '0;
            mdio_reg_wr <= '0;
            for (int n = 0; n < NUM_MDIO; n++) begin
                if (wr_en && chan_hit(wr_addr, n)) begin
                    case (wr_addr[1:0])
                        2'd0: mdio_wr_data[16*n +: 8]   <= wr_data;
                        2'd1: mdio_wr_data[16*n+8 +: 8] <= wr_data;
                        2'd2: begin
                            mdio_reg_addr[5*n +: 5] <= wr_data[4:0];
                            mdio_phy_addr[5*n +: 3] <= wr_data[7:5];
                        end
                        default: begin
                            mdio_phy_addr[5*n+3 +: 2] <= wr_data[1:0];
                            mdio_reg_rd[n] <= wr_data[5] & ~mdio_busy[n];
                            mdio_reg_wr[n] <= wr_data[6] & ~mdio_busy[n];
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mgmt_register_bank.sv
// Bench for mgmt_register_bank: read expectations queued at issue, checked with latency when rd_valid appears.
module tb_mgmt_register_bank;
    localparam int NM = 2;
    localparam int NI = 8;
    localparam int WT = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rd_en = 1'b0;
    logic [15:0]     rd_addr = '0;
    logic            rd_valid;
    logic [7:0]      rd_data;
    logic            wr_en = 1'b0;
    logic [15:0]     wr_addr = '0;
    logic [7:0]      wr_data = '0;
    logic            idcode_valid = 1'b1;
    logic [31:0]     idcode = 32'h12345678;
    logic [NI-1:0]   irq_src = '0;
    logic            irq;
    logic [NM-1:0]   mdio_busy = '0;
    logic [16*NM-1:0] mdio_rd_data = 32'h5a3c_c3a5;
    logic [16*NM-1:0] mdio_wr_data;
    logic [5*NM-1:0] mdio_reg_addr, mdio_phy_addr;
    logic [NM-1:0]   mdio_reg_rd, mdio_reg_wr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0]  dat;
        logic [15:0] addr;
        int          issued;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mgmt_register_bank #(.NUM_MDIO(NM), .NUM_IRQ(NI), .WAIT_TIMEOUT(WT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .idcode_valid(idcode_valid), .idcode(idcode),
        .irq_src(irq_src), .irq(irq),
        .mdio_busy(mdio_busy), .mdio_rd_data(mdio_rd_data), .mdio_wr_data(mdio_wr_data),
        .mdio_reg_addr(mdio_reg_addr), .mdio_phy_addr(mdio_phy_addr),
        .mdio_reg_rd(mdio_reg_rd), .mdio_reg_wr(mdio_reg_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_spurious", 32'(rd_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rd_data@%h", e.addr), 32'(rd_data), 32'(e.dat));
                chk($sformatf("rd_lat@%h", e.addr), 32'(cyc - e.issued), 32'(e.lat));
            end
        end
    end

    task automatic rd(input logic [15:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        e.dat = d; e.addr = a; e.issued = cyc; e.lat = lat;
        rd_en = 1'b1; rd_addr = a;
        sb.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({pfx, "_irq"}, 32'(irq), 32'd0);
        chk({pfx, "_wr_data"}, 32'(mdio_wr_data), 32'd0);
        chk({pfx, "_reg_addr"}, 32'(mdio_reg_addr), 32'd0);
        chk({pfx, "_phy_addr"}, 32'(mdio_phy_addr), 32'd0);
        chk({pfx, "_strobes"}, 32'({mdio_reg_rd, mdio_reg_wr}), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // idcode, back-to-back, MSB first
        rd(16'h0000, 8'h12, 1); rd(16'h0001, 8'h34, 1);
        rd(16'h0002, 8'h56, 1); rd(16'h0003, 8'h78, 1);
        drain();

        // IRQ status / enable
        rd(16'h0020, 8'h00, 1); rd(16'h0021, 8'h00, 1); drain();
        irq_src[3] = 1'b1; @(negedge clk); irq_src[3] = 1'b0; @(negedge clk);
        rd(16'h0020, 8'h08, 1); drain();
`ifdef MGMT_IRQ_MASK_EN
        chk("irq_masked", 32'(irq), 32'd0);
        wr(16'h0022, 8'h08);
        rd(16'h0022, 8'h08, 1); drain();
`else
        wr(16'h0022, 8'hFF);
        rd(16'h0022, 8'h00, 1); drain();
`endif
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);

        // W1C coincident with a new edge: set wins
        wr_en = 1'b1; wr_addr = 16'h0020; wr_data = 8'h08; irq_src[3] = 1'b1;
        @(negedge clk); wr_en = 1'b0;
        rd(16'h0020, 8'h08, 1); drain();
        wr(16'h0020, 8'h08);
        rd(16'h0020, 8'h00, 1); drain();
        chk("irq_clr", 32'(irq), 32'd0);
        irq_src[3] = 1'b0;

        // read and W1C in the same cycle: read sees pre-write value
        irq_src[5] = 1'b1; @(negedge clk); irq_src[5] = 1'b0; @(negedge clk);
        wr_en = 1'b1; wr_addr = 16'h0020; wr_data = 8'h20;
        rd(16'h0020, 8'h20, 1);
        wr_en = 1'b0;
        rd(16'h0020, 8'h00, 1); drain();

        // MDIO channel 1 command sequence
        wr(16'h004C, 8'hCD); wr(16'h004D, 8'hAB); wr(16'h004E, 8'h25);
        chk("strobe_early", 32'({mdio_reg_rd, mdio_reg_wr}), 32'd0);
        wr(16'h004F, 8'h41);
        chk("reg_wr_pulse", 32'(mdio_reg_wr), 32'h2);
        chk("reg_rd_quiet", 32'(mdio_reg_rd), 32'h0);
        @(negedge clk);
        chk("reg_wr_single", 32'(mdio_reg_wr), 32'h0);
        chk("ch1_wr_data", 32'(mdio_wr_data[31:16]), 32'hABCD);
        chk("ch1_reg_addr", 32'(mdio_reg_addr[9:5]), 32'd5);
        chk("ch1_phy_addr", 32'(mdio_phy_addr[9:5]), 32'd9);
        chk("ch0_wr_data", 32'(mdio_wr_data[15:0]), 32'h0);
        rd(16'h0048, 8'hA5, 1); rd(16'h0049, 8'hC3, 1); rd(16'h004C, 8'h3C, 1);
        rd(16'h004D, 8'h5A, 1); rd(16'h004E, 8'h00, 1); rd(16'h004B, 8'h00, 1);
        drain();

        // busy latch and busy-write error
        mdio_busy[0] = 1'b1;
        rd(16'h0048, 8'hA5, 1); rd(16'h004B, 8'h80, 1); drain();
        wr(16'h004B, 8'h60);
        chk("busy_no_strobe", 32'({mdio_reg_rd, mdio_reg_wr}), 32'd0);
        rd(16'h0024, 8'h02, 1); drain();
        wr(16'h0024, 8'h02);
        rd(16'h0024, 8'h00, 1); drain();
        mdio_busy[0] = 1'b0;

        // channels past NUM_MDIO and unmapped space
        wr(16'h0050, 8'hFF); wr(16'h0053, 8'h60);
        chk("ch2_ignored", 32'(mdio_wr_data), 32'hABCD0000);
        rd(16'h0050, 8'h00, 1); rd(16'h0030, 8'h00, 1); rd(16'h0053, 8'h00, 1); drain();

        // idcode stall timeout
        idcode_valid = 1'b0;
        rd(16'h0001, 8'hFF, WT + 1); drain();
        rd(16'h0024, 8'h01, 1); drain();
        wr(16'h0024, 8'h01);
        rd(16'h0024, 8'h00, 1); drain();

        // stall resolved by idcode_valid; rd_en while pending is dropped
        rd(16'h0002, 8'h56, 4);
        rd_en = 1'b1; rd_addr = 16'h0000; @(negedge clk); rd_en = 1'b0;
        @(negedge clk); idcode_valid = 1'b1;
        drain();
        rd(16'h0024, 8'h00, 1); drain();

        // reset during a stalled read
        irq_src[6] = 1'b1; @(negedge clk); irq_src[6] = 1'b0;
        idcode_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 16'h0003; @(negedge clk); rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; irq_src[1] = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst1");
        idcode_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rd(16'h0020, 8'h02, 1); rd(16'h0024, 8'h00, 1); rd(16'h004B, 8'h00, 1);
        rd(16'h0000, 8'h12, 1); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
endmodule
